// File: rtl/regfile_scheduler_if.sv
// Bundle between the register-array scheduler and its environment:
// issue/response, writeback and load write requests, and the array buses.
// The slave modport is the scheduler's view; master is the environment's.
interface regfile_scheduler_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_rd_en;
  logic        rsp_valid;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_ra;
  logic [4:0]  rf_rb;
  logic [31:0] rf_a_bus;
  logic [31:0] rf_b_bus;
  logic [31:0] busy_mask;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
    input  wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data,
    input  rf_a_bus, rf_b_bus,
    output iss_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
    output wb_ready, ld_ready, rf_we, rf_wsel, rf_wdata,
    output rf_ra, rf_rb, busy_mask
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
    output wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data,
    output rf_a_bus, rf_b_bus,
    input  iss_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
    input  wb_ready, ld_ready, rf_we, rf_wsel, rf_wdata,
    input  rf_ra, rf_rb, busy_mask
  );
endinterface

// File: rtl/regfile_scheduler.sv
// Issue/writeback sequencer for a 32x32 register array: busy scoreboard,
// RAW/WAW issue stall, single write-port arbitration and one-cycle operand
// return. Optional macro REGFILE_BYPASS_EN forwards the granted write to a
// same-cycle issue instead of stalling it.
module regfile_scheduler #(
  parameter int WB_PRIORITY = 0
) (
  input logic               clk,
  input logic               reset,
  regfile_scheduler_if.slave bus
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {GNT_WB, GNT_LD} last_gnt_e;

  logic [31:0] busy_q, busy_d;
  last_gnt_e   last_q, last_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_a_q, rsp_a_d;
  logic [31:0] rsp_b_q, rsp_b_d;

  logic        wb_gnt, ld_gnt, wr_we;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        accept;
  logic [31:0] op_a, op_b;

  // A register is a hazard while busy; with forwarding the write granted this
  // cycle resolves it early.
  function automatic logic hazard(input logic [31:0] busy, input logic [4:0] r,
                                  input logic fwd_we, input logic [4:0] fwd_rd);
    hazard = busy[r] && (r != '0);
    if (BYPASS && fwd_we && (fwd_rd == r))
      hazard = 1'b0;
  endfunction

  // Write-port arbitration; grants depend only on valids and the last-grant pointer.
  always_comb begin
    wb_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      if (WB_PRIORITY != 0) begin
        wb_gnt = bus.wb_valid;
        ld_gnt = bus.ld_valid && !bus.wb_valid;
      end else begin
        wb_gnt = bus.wb_valid && (!bus.ld_valid || (last_q == GNT_LD));
        ld_gnt = bus.ld_valid && !wb_gnt;
      end
    end
    wr_rd   = wb_gnt ? bus.wb_rd   : bus.ld_rd;
    wr_data = wb_gnt ? bus.wb_data : bus.ld_data;
    // A granted write to x0 is consumed but never reaches the array.
    wr_we   = (wb_gnt || ld_gnt) && (wr_rd != '0);
  end

  // Issue acceptance, operand selection and scoreboard / pointer next state.
  always_comb begin
    accept = bus.iss_valid && !reset
          && !hazard(busy_q, bus.iss_rs1, wr_we, wr_rd)
          && !hazard(busy_q, bus.iss_rs2, wr_we, wr_rd)
          && !(bus.iss_rd_en && hazard(busy_q, bus.iss_rd, wr_we, wr_rd));

    op_a = bus.rf_a_bus;
    op_b = bus.rf_b_bus;
    if (BYPASS && wr_we && (wr_rd == bus.iss_rs1)) op_a = wr_data;
    if (BYPASS && wr_we && (wr_rd == bus.iss_rs2)) op_b = wr_data;

    rsp_a_d = accept ? op_a : rsp_a_q;
    rsp_b_d = accept ? op_b : rsp_b_q;

    // Clear first so a same-edge reservation of the same register wins.
    busy_d = busy_q;
    if (wr_we)
      busy_d[wr_rd] = 1'b0;
    if (accept && bus.iss_rd_en)
      busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    last_d = last_q;
    if (wb_gnt)      last_d = GNT_WB;
    else if (ld_gnt) last_d = GNT_LD;
  end

  // Registered scoreboard, arbitration pointer and operand response.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      last_q      <= GNT_LD;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      last_q      <= last_d;
      rsp_valid_q <= accept;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
    end
  end

  // Output drive; array indices and write fields rest at zero when unused.
  always_comb begin
    bus.iss_ready    = accept;
    bus.wb_ready     = wb_gnt;
    bus.ld_ready     = ld_gnt;
    bus.rf_we        = wr_we;
    bus.rf_wsel      = wr_we ? wr_rd   : '0;
    bus.rf_wdata     = wr_we ? wr_data : '0;
    bus.rf_ra        = accept ? bus.iss_rs1 : '0;
    bus.rf_rb        = accept ? bus.iss_rs2 : '0;
    bus.rsp_valid    = rsp_valid_q;
    bus.rsp_rs1_data = rsp_a_q;
    bus.rsp_rs2_data = rsp_b_q;
    bus.busy_mask    = busy_q;
  end

endmodule

// File: doc/regfile_scheduler.md
# regfile_scheduler

Sequencing and arbitration controller for the 32×32 register array. It sits between the issue stage and writeback/load units and the array's two read buses and single write port. It keeps a per-register busy scoreboard, stalls issue on RAW/WAW hazards, and arbitrates the single write port between the writeback and load-return paths. It returns both source operands one cycle after issue is accepted.

## Interface
Parameters:
- WB_PRIORITY, 0, 0 = round-robin write arbitration; 1 = writeback always wins over load.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- iss_valid  in  1  issue request
- iss_ready  out  1  issue accepted this cycle (combinational)
- iss_rs1, iss_rs2  in  5  source register indices
- iss_rd  in  5  destination to reserve
- iss_rd_en  in  1  reserve iss_rd on accept
- rsp_valid  out  1  operand response valid
- rsp_rs1_data, rsp_rs2_data  out  32  operand values
- wb_valid / ld_valid  in  1  write requests (writeback / load return)
- wb_ready / ld_ready  out  1  write granted this cycle (combinational)
- wb_rd / ld_rd  in  5  write destination
- wb_data / ld_data  in  32  write data
- rf_we  out  1  array write strobe
- rf_wsel  out  5  array write select
- rf_wdata  out  32  array write data
- rf_ra, rf_rb  out  5  array read-enable indices for the A and B buses
- rf_a_bus, rf_b_bus  in  32  array read data (combinational from rf_ra/rf_rb)
- busy_mask  out  32  scoreboard; bit 0 is always 0

## Operation
- Scoreboard busy[31:0].
  - Reset value: 0.
  - Writes to busy[0] are ignored.
- Issue acceptance:
  - iss_ready = iss_valid && !hz(rs1) && !hz(rs2) && !(iss_rd_en && hz(iss_rd)).
  - hz(r) = busy[r] && r≠0, with the bypass modification described under Configuration.
- On issue accept:
  - rf_ra=rs1 and rf_rb=rs2 are driven in the same cycle.
  - rf_a_bus/rf_b_bus are captured into rsp_*_data.
  - rsp_valid=1 in the next cycle only.
  - If iss_rd_en and iss_rd≠0, busy[iss_rd] is set at that edge.
- When idle, rf_ra/rf_rb = 0.
- Write arbitration: at most one grant per cycle.
  - WB_PRIORITY=0: round-robin. The last-grant pointer resets to favour wb; with both valid, grants alternate wb, ld, wb, …
  - WB_PRIORITY=1: wb always wins.
- On a grant:
  - rf_we=1, rf_wsel=rd, rf_wdata=data.
  - busy[rd] is cleared at the edge.
  - rd=0: the request is granted with rf_we=0 and data is discarded.
- A write to a non-busy register is legal and is performed.
- Same-edge set and clear of one busy bit: set wins.
- Reset mid-operation clears busy, the rr pointer and rsp_valid. In-flight requests are not replayed.

## Timing
- Output reset values:
  - rsp_valid=0, rsp_*_data=0, busy_mask=0.
  - rf_we=0, rf_wsel=0, rf_wdata=0, rf_ra=0, rf_rb=0.
  - All ready outputs=0.
- Read latency: accept at cycle N → rsp_valid at N+1.
- Throughput: one issue plus one write per cycle.
- Write visibility: the array updates at the end of the grant cycle.
  - Without bypass, a dependent issue is accepted no earlier than grant+1; its response arrives at grant+2.
- Ready signals depend on same-cycle valids and registered state only. There is no combinational path from ready to valid.

## Configuration
- REGFILE_BYPASS_EN defined:
  - hz(r) is false when the granted write this cycle targets r (r≠0).
  - The matching rsp operand takes rf_wdata instead of rf_a_bus/rf_b_bus.
  - WAW: the issue is accepted; busy stays set (set wins).
- REGFILE_BYPASS_EN undefined:
  - No forwarding. A busy source stalls until the cycle after its write is granted.

## Test plan
- Reset, then issue rs1=0, rs2=0, rd=5 → iss_ready=1; next cycle rsp_valid=1, both data 0, busy_mask=0x0000_0020.
- busy[5] set, issue rs1=5; wb rd=5 data 0xDEADBEEF →
  - no bypass: stall, accept at grant+1, rsp_rs1_data=0xDEADBEEF.
  - bypass: accept in the grant cycle, same data.
- wb (rd=1) and ld (rd=2) held valid, WB_PRIORITY=0 → grants wb, ld, wb, ld; with WB_PRIORITY=1, wb only.
- wb rd=0 data 0xFFFF_FFFF → wb_ready=1, rf_we=0; a later read of x0 returns 0.
- busy[7] set, issue rd=7 in the same cycle wb clears 7 →
  - bypass: accepted, busy_mask bit 7 stays 1.
  - no bypass: iss_ready=0.
- Drive busy_mask=0x0000_0F00 with a response pending, then assert reset → next cycle busy_mask=0, rsp_valid=0, rf_we=0.
